// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit FSM state encoding, data width
// and the default baud divisor.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEFAULT_BAUD_DIV = 868;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each bit
// (bit_tick) and the cycle just before it (pre_tick). clear restarts a period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO and serialises start, 8 data bits
// LSB-first, optional even parity (`UART_PARITY_EN) and STOP_BITS stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd_en,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_W - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e              state, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx, bit_idx_d;
    logic                   tx_d;
    logic                   done_d;
    logic                   bit_tick;
    logic                   pre_tick;

    // Restarting the timer in LATCH makes the start bit exactly one period.
    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == LATCH),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

`ifdef UART_PARITY_EN
    logic parity_q;

    // NOTE: a pure data register captured before use needs no reset.
    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_idx_d = bit_idx;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && !fifo_empty) state_d = FETCH;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                shift_d   = fifo_data;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_d = '0;
`ifdef UART_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                // tx_done is registered, so it is set one cycle ahead of the frame end.
                if (pre_tick && bit_idx == LAST_STOP) done_d = 1'b1;
                if (bit_tick) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = (tx_en && !fifo_empty) ? FETCH : IDLE;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so tx itself is a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_idx    <= bit_idx_d;
            tx         <= tx_d;
            fifo_rd_en <= (state_d == FETCH);
            tx_busy    <= (state_d != IDLE);
            tx_done    <= done_d;
        end
    end

endmodule
